// File: rtl/rvfi_commit_monitor.sv
// Retirement-side monitor: numbers up to NUM_CH commits per cycle in program order,
// detects halt (sustained request or self-looping retire) and a no-commit watchdog timeout.

module rvfi_commit_lane #(
    parameter int ORDER_W = 64,
    parameter int CNT_W   = 2
) (
    input  logic               commit_i,
    input  logic [31:0]        pc_rdata_i,
    input  logic [31:0]        pc_wdata_i,
    input  logic [ORDER_W-1:0] base_i,
    input  logic [CNT_W-1:0]   prefix_i,
    output logic [ORDER_W-1:0] order_o,
    output logic               loop_o
);
    assign order_o = base_i + ORDER_W'(prefix_i);
    assign loop_o  = commit_i & (pc_wdata_i == pc_rdata_i);
endmodule

module rvfi_commit_monitor #(
    parameter int NUM_CH   = 2,
    parameter int ORDER_W  = 64,
    parameter int HALT_CNT = 2,
    parameter int TIMEOUT  = 1000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic [NUM_CH-1:0]              commit,
    input  logic [NUM_CH-1:0][31:0]        pc_rdata,
    input  logic [NUM_CH-1:0][31:0]        pc_wdata,
    input  logic                           halt_req,
    output logic [NUM_CH-1:0][ORDER_W-1:0] order,
    output logic [ORDER_W-1:0]             commit_total,
    output logic                           halt,
    output logic                           timeout
);
    localparam int CNT_W    = $clog2(NUM_CH + 1);
    localparam int STREAK_W = $clog2(HALT_CNT + 1);
    localparam int IDLE_W   = $clog2(TIMEOUT + 2);

    localparam logic [STREAK_W-1:0] HALT_SAT  = STREAK_W'(HALT_CNT);
    localparam logic [IDLE_W-1:0]   IDLE_SAT  = IDLE_W'(TIMEOUT);
    localparam logic [IDLE_W-1:0]   IDLE_LAST = IDLE_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    localparam logic [1:0] ST_RUN       = 2'd0;
    localparam logic [1:0] ST_HALTED    = 2'd1;
    localparam logic [1:0] ST_TIMED_OUT = 2'd2;

    logic [ORDER_W-1:0]  base_q, base_d;
    logic [STREAK_W-1:0] req_cnt_q, req_cnt_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic [1:0]          state_q, state_d;

    logic [NUM_CH:0][CNT_W-1:0]     prefix;
    logic [NUM_CH-1:0][ORDER_W-1:0] lane_order;
    logic [NUM_CH-1:0]              loop;
    logic                           any_commit, req_hit, loop_hit, hit, idle_fire;

    // prefix[i] = number of valid commits older than channel i; prefix[NUM_CH] is the cycle total
    always_comb begin
        prefix[0] = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            prefix[i+1] = prefix[i] + CNT_W'(commit[i]);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        rvfi_commit_lane #(
            .ORDER_W (ORDER_W),
            .CNT_W   (CNT_W)
        ) u_lane (
            .commit_i   (commit[g]),
            .pc_rdata_i (pc_rdata[g]),
            .pc_wdata_i (pc_wdata[g]),
            .base_i     (base_q),
            .prefix_i   (prefix[g]),
            .order_o    (lane_order[g]),
            .loop_o     (loop[g])
        );
    end

    assign any_commit = |commit;
    assign req_hit    = halt_req & (req_cnt_q >= HALT_SAT);
    assign loop_hit   = (streak_q >= HALT_SAT);
    assign hit        = req_hit | loop_hit;
    assign idle_fire  = (TIMEOUT != 0) && (idle_q == IDLE_LAST) && !any_commit;

    always_comb begin
        base_d    = base_q + ORDER_W'(prefix[NUM_CH]);
        req_cnt_d = '0;
        if (halt_req) begin
            req_cnt_d = (req_cnt_q < HALT_SAT) ? req_cnt_q + STREAK_W'(1) : req_cnt_q;
        end

        // Oldest-to-youngest scan so a younger non-loop retire breaks the streak
        streak_d = streak_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (commit[i]) begin
                if (!loop[i]) begin
                    streak_d = '0;
                end else if (streak_d < HALT_SAT) begin
                    streak_d = streak_d + STREAK_W'(1);
                end
            end
        end

        idle_d  = idle_q;
        state_d = state_q;
        if (state_q == ST_RUN) begin
            if (any_commit) begin
                idle_d = '0;
            end else if (idle_q < IDLE_SAT) begin
                idle_d = idle_q + IDLE_W'(1);
            end
            if (hit) begin
                state_d = ST_HALTED;
            end else if (idle_fire) begin
                state_d = ST_TIMED_OUT;
            end
        end

        if (clear) begin
            base_d    = '0;
            req_cnt_d = '0;
            streak_d  = '0;
            idle_d    = '0;
            state_d   = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q    <= '0;
            req_cnt_q <= '0;
            streak_q  <= '0;
            idle_q    <= '0;
            state_q   <= ST_RUN;
        end else begin
            base_q    <= base_d;
            req_cnt_q <= req_cnt_d;
            streak_q  <= streak_d;
            idle_q    <= idle_d;
            state_q   <= state_d;
        end
    end

    // Orders are forced to zero while reset is held, independent of the commit inputs
    assign order        = rst ? lane_order : '0;
    assign commit_total = base_q;
    assign halt         = (state_q == ST_HALTED) | ((state_q == ST_RUN) & hit);
    assign timeout      = (state_q == ST_TIMED_OUT);

endmodule

// File: tb/tb_rvfi_commit_monitor.sv
// Directed plus randomized bench for rvfi_commit_monitor against a counting reference model.

module tb_rvfi_commit_monitor;
    localparam int NUM_CH   = 2;
    localparam int ORDER_W  = 64;
    localparam int HALT_CNT = 2;
    localparam int TIMEOUT  = 8;

    logic                           clk = 1'b0;
    logic                           rst;
    logic                           clear;
    logic [NUM_CH-1:0]              commit;
    logic [NUM_CH-1:0][31:0]        pc_rdata;
    logic [NUM_CH-1:0][31:0]        pc_wdata;
    logic                           halt_req;
    logic [NUM_CH-1:0][ORDER_W-1:0] order;
    logic [ORDER_W-1:0]             commit_total;
    logic                           halt;
    logic                           timeout;

    int checks   = 0;
    int failures = 0;

    // Reference model: plain counts of events since reset/clear
    logic [63:0] m_base;
    int          m_req, m_streak, m_idle;
    bit          m_halted, m_to;

    rvfi_commit_monitor #(
        .NUM_CH   (NUM_CH),
        .ORDER_W  (ORDER_W),
        .HALT_CNT (HALT_CNT),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .commit       (commit),
        .pc_rdata     (pc_rdata),
        .pc_wdata     (pc_wdata),
        .halt_req     (halt_req),
        .order        (order),
        .commit_total (commit_total),
        .halt         (halt),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_base = '0; m_req = 0; m_streak = 0; m_idle = 0; m_halted = 0; m_to = 0;
    endtask

    function automatic bit m_hit();
        return (halt_req && m_req >= HALT_CNT) || (m_streak >= HALT_CNT);
    endfunction

    task automatic check_all();
        bit          running;
        logic [1:0]  mask;
        logic [63:0] exp_ord;
        running = !m_halted && !m_to;
        chk("commit_total", commit_total, m_base);
        chk("halt", {63'd0, halt}, {63'd0, m_halted || (running && m_hit())});
        chk("timeout", {63'd0, timeout}, {63'd0, m_to});
        for (int i = 0; i < NUM_CH; i++) begin
            if (commit[i]) begin
                mask    = 2'((1 << i) - 1);
                exp_ord = m_base + 64'($countones(commit & mask));
                chk($sformatf("order%0d", i), order[i], exp_ord);
            end
        end
    endtask

    task automatic model_step();
        bit running, hit, fire;
        if (clear) begin
            model_reset();
        end else begin
            running = !m_halted && !m_to;
            hit     = m_hit();
            fire    = running && (commit == '0) && (m_idle + 1 == TIMEOUT);
            m_base  = m_base + 64'($countones(commit));
            m_req   = halt_req ? ((m_req < 100) ? m_req + 1 : m_req) : 0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (commit[i]) begin
                    if (pc_wdata[i] == pc_rdata[i]) m_streak = (m_streak < 100) ? m_streak + 1 : m_streak;
                    else m_streak = 0;
                end
            end
            if (running) begin
                m_idle = (commit != '0) ? 0 : ((m_idle < 100) ? m_idle + 1 : m_idle);
                if (hit) m_halted = 1;
                else if (fire) m_to = 1;
            end
        end
    endtask

    // Called at posedge+1: apply inputs, check at the falling edge, advance model past the next rising edge
    task automatic drive(input logic [1:0] c, input logic [31:0] r0, input logic [31:0] w0,
                         input logic [31:0] r1, input logic [31:0] w1, input logic hr, input logic cl);
        commit   = c;
        pc_rdata = {r1, r0};
        pc_wdata = {w1, w0};
        halt_req = hr;
        clear    = cl;
        @(negedge clk);
        check_all();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic plain(input logic [1:0] c, input logic hr, input logic cl);
        drive(c, 32'h100, 32'h104, 32'h104, 32'h108, hr, cl);
    endtask

    initial begin
        logic [31:0] r0, r1, w0, w1;
        logic [1:0]  c;
        bit          idle_seg;

        rst = 1'b0; clear = 1'b0; halt_req = 1'b0; commit = 2'b11;
        pc_rdata = {32'h104, 32'h100};
        pc_wdata = {32'h108, 32'h104};
        model_reset();

        // Reset held with commits present
        repeat (3) begin
            @(negedge clk);
            chk("rst_total", commit_total, 64'd0);
            chk("rst_halt", {63'd0, halt}, 64'd0);
            chk("rst_timeout", {63'd0, timeout}, 64'd0);
            chk("rst_order0", order[0], 64'd0);
            chk("rst_order1", order[1], 64'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Ordering
        repeat (3) plain(2'b11, 1'b0, 1'b0);
        chk("ord_total6", commit_total, 64'd6);
        plain(2'b10, 1'b0, 1'b0);
        chk("ord_total7", commit_total, 64'd7);

        // Halt request 1,0,1,1,1
        plain(2'b11, 1'b1, 1'b0);
        plain(2'b11, 1'b0, 1'b0);
        plain(2'b11, 1'b1, 1'b0);
        plain(2'b11, 1'b1, 1'b0);
        halt_req = 1'b1;
        #1;
        chk("req_hit_comb", {63'd0, halt}, 64'd1);
        plain(2'b11, 1'b1, 1'b0);
        plain(2'b11, 1'b0, 1'b0);
        chk("req_halt_hold", {63'd0, halt}, 64'd1);
        plain(2'b00, 1'b0, 1'b1);
        chk("clr_total", commit_total, 64'd0);
        chk("clr_halt", {63'd0, halt}, 64'd0);

        // Self-loop on ch0 twice
        drive(2'b01, 32'h60, 32'h60, 32'h0, 32'h0, 1'b0, 1'b0);
        drive(2'b01, 32'h60, 32'h60, 32'h0, 32'h0, 1'b0, 1'b0);
        commit = 2'b00;
        #1;
        chk("loop_halt", {63'd0, halt}, 64'd1);
        plain(2'b00, 1'b0, 1'b0);
        plain(2'b00, 1'b0, 1'b1);

        // Loop streak broken by a younger non-loop commit
        drive(2'b01, 32'h60, 32'h60, 32'h0, 32'h0, 1'b0, 1'b0);
        drive(2'b11, 32'h60, 32'h60, 32'h64, 32'h68, 1'b0, 1'b0);
        commit = 2'b00;
        #1;
        chk("loop_broken", {63'd0, halt}, 64'd0);
        plain(2'b00, 1'b0, 1'b0);
        plain(2'b00, 1'b0, 1'b1);

        // Watchdog
        plain(2'b11, 1'b0, 1'b0);
        repeat (TIMEOUT) plain(2'b00, 1'b0, 1'b0);
        chk("wd_fire", {63'd0, timeout}, 64'd1);
        plain(2'b00, 1'b0, 1'b0);
        plain(2'b11, 1'b0, 1'b0);
        chk("wd_sticky", {63'd0, timeout}, 64'd1);
        chk("wd_total", commit_total, 64'd4);
        plain(2'b00, 1'b0, 1'b1);
        chk("wd_clr_timeout", {63'd0, timeout}, 64'd0);
        chk("wd_clr_total", commit_total, 64'd0);

        // Async reset while halted
        repeat (3) plain(2'b11, 1'b1, 1'b0);
        plain(2'b11, 1'b0, 1'b0);
        chk("pre_async_halt", {63'd0, halt}, 64'd1);
        chk("pre_async_total", commit_total, 64'd8);
        #3;
        rst = 1'b0;
        #1;
        chk("async_halt", {63'd0, halt}, 64'd0);
        chk("async_total", commit_total, 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            idle_seg = ((k / 40) % 3) == 2;
            c  = idle_seg ? 2'b00 : 2'($urandom_range(0, 3));
            r0 = $urandom;
            r1 = $urandom;
            w0 = ($urandom_range(0, 2) == 0) ? r0 : r0 + 32'd4;
            w1 = ($urandom_range(0, 2) == 0) ? r1 : r1 + 32'd4;
            drive(c, r0, w0, r1, w1, $urandom_range(0, 5) == 0, $urandom_range(0, 24) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rvfi_commit_monitor.md
Name: rvfi_commit_monitor

Overview:
- Parametrised successor to the single-issue commit/halt logic in the mp4 bench top.
- Assigns RVFI order numbers to up to NUM_CH commits per cycle, in program order, for superscalar/OoO retirement.
- Detects halt from either a sustained halt request or a self-looping retired instruction, and flags a no-commit watchdog timeout.
- Sits between the DUT's retirement taps and the rvfi interface in the bench; it is synthesizable so it can also live inside the DUT.

Parameters:
- NUM_CH, 2, commit channels per cycle; channel 0 is oldest.
- ORDER_W, 64, width of order and commit counters.
- HALT_CNT, 2, consecutive qualifying events required before halt.
- TIMEOUT, 1000, idle cycles before timeout; 0 disables the watchdog.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of counters, streaks and FSM.
- commit  in  NUM_CH  per-channel retire valid.
- pc_rdata  in  NUM_CH*32  per-channel PC of the retiring instruction.
- pc_wdata  in  NUM_CH*32  per-channel next PC.
- halt_req  in  1  DUT halt hint.
- order  out  NUM_CH*ORDER_W  order for each channel this cycle; meaningful only where commit[i]=1.
- commit_total  out  ORDER_W  registered count of all commits so far.
- halt  out  1  halt indication, drives rvfi.halt.
- timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (rst=0, async) forces all registers to 0: base, req_cnt, streak, idle_cnt, FSM=RUN. Hence commit_total=0, halt=0, timeout=0, order=0 while in reset.
- clear=1 at an edge has the same effect synchronously and takes priority over every other update that cycle.

Order assignment:
- order[i] = base + popcount(commit[i-1:0]); combinational, zero latency.
- Every edge: base <= base + popcount(commit). The sum wraps modulo 2^ORDER_W.
- commit_total = base.
- Non-contiguous valids are legal (e.g. 2'b10 gives order[1]=base).

Halt-request path:
- req_cnt counts consecutive cycles with halt_req=1, saturating at HALT_CNT.
- Any cycle with halt_req=0 resets req_cnt to 0.
- req_hit = halt_req & (req_cnt >= HALT_CNT).

Self-loop path:
- A loop commit is commit[i] & (pc_wdata[i] == pc_rdata[i]).
- Committed channels are scanned oldest to youngest; each non-loop commit sets streak to 0, each loop commit increments it.
- Saturates at HALT_CNT. No commit this cycle leaves streak unchanged.
- loop_hit = (streak >= HALT_CNT), using the registered value.

FSM (registered):
- RUN -> HALTED when req_hit | loop_hit.
- RUN -> TIMED_OUT when TIMEOUT != 0 and idle_cnt == TIMEOUT-1 and commit == 0.
- If both conditions are true in the same cycle, HALTED wins.
- HALTED and TIMED_OUT are terminal until rst or clear.

Outputs by state:
- halt = (state == HALTED) | (state == RUN & (req_hit | loop_hit)). It asserts combinationally on the first hit and then holds.
- timeout = (state == TIMED_OUT).

Watchdog:
- idle_cnt increments on each cycle with commit == 0 and resets to 0 on any commit.
- It saturates and is frozen outside RUN.
- Commits keep updating base in every state.

Test Plan:
- Reset: hold rst=0 for 3 cycles with commit=2'b11 -> commit_total=0, halt=0, timeout=0. Release; the first commit of 2'b11 gives order[0]=0, order[1]=1.
- Ordering: commit=2'b11 for 3 cycles -> orders (0,1), (2,3), (4,5), commit_total=6. Then commit=2'b10 -> order[1]=6 and commit_total becomes 7.
- Halt request (HALT_CNT=2): halt_req pattern 1,0,1,1,1 -> halt=0 for the first four cycles, halt=1 in the fifth, and it stays 1 after halt_req drops.
- Self-loop: ch0 retires pc 0x60 -> 0x60 in two consecutive commit cycles -> halt=1 in the following cycle. Repeat with ch1 retiring 0x64 -> 0x68 in the same cycle as the second loop commit -> streak=0, no halt.
- Watchdog (TIMEOUT=8): no commits for 8 cycles -> timeout=1 from the 9th cycle, sticky. A commit then keeps it at 1 and advances commit_total. clear=1 -> timeout=0, commit_total=0.
- Async reset mid-HALTED: drive rst=0 between edges -> halt and commit_total go to 0 immediately, with no clock edge required.
